dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single data-memory port (`dmem`) between the MIPS core's load/store path (master 0) and a second bus master (master 1, e.g. a DMA or accelerator fetch engine). It sits between the masters and `dmem` in `system`. It decides per cycle which master drives the memory address, write-enable and write data, and registers the read data back to the winning master. Fairness is enforced by a starvation counter and a bounded lock/burst mechanism.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single dmem port between two bus masters.
// Optional round-robin conflict policy: define DMEM_ARB_RR_EN.
module dmem_arbiter #(
    parameter int AW         = 6,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rd,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rd,
    output logic          m1_rvalid,
    input  logic          m1_lock,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);

    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nx;
    logic          burst_end;
    logic          fair_m1;
    logic          m1_pri;

    assign burst_end = (burst_cnt == BW'(BURST_MAX));

`ifdef DMEM_ARB_RR_EN
    // 1 when master 1 won the most recent conflict
    logic last_win;

    // Remember the conflict winner so the other master takes the next one
    always_ff @(posedge clk) begin
        if (!rst)
            last_win <= 1'b1;
        else if (m0_req && m1_req)
            last_win <= m1_gnt;
    end

    assign fair_m1 = !last_win;
`else
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    // Count consecutive lost cycles of master 1, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst)
            starve_cnt <= '0;
        else if (!m1_req || m1_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign fair_m1 = (starve_cnt == SW'(STARVE_MAX));
`endif

    // Lock state and burst length register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    // Lock entry on a locked master 1 grant, exit on release or full burst
    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        unique case (state)
            IDLE: begin
                if (m1_gnt && m1_lock) begin
                    state_nx = LOCKED;
                    burst_nx = BW'(1);
                end
            end
            LOCKED: begin
                if (!m1_lock || !m1_req || burst_end) begin
                    state_nx = IDLE;
                    burst_nx = '0;
                end else begin
                    burst_nx = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                burst_nx = '0;
            end
        endcase
    end

    // Grant decision; a full burst yields one cycle to a waiting master 0
    always_comb begin
        m1_pri = fair_m1;
        if (state == LOCKED)
            m1_pri = !(burst_end && m0_req);
        m1_gnt = rst && m1_req && (m1_pri || !m0_req);
        m0_gnt = rst && m0_req && !m1_gnt;
    end

    // Memory port follows the granted master, master 0 inputs when idle
    always_comb begin
        mem_a  = m1_gnt ? m1_addr : m0_addr;
        mem_d  = m1_gnt ? m1_wd : m0_wd;
        mem_we = (m0_gnt && m0_we) || (m1_gnt && m1_we);
    end

    // Capture read data at the grant edge; rvalid marks the following cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_rd     <= '0;
            m0_rvalid <= 1'b0;
            m1_rd     <= '0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we)
                m0_rd <= mem_q;
            if (m1_gnt && !m1_we)
                m1_rd <= mem_q;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter.
// Honours DMEM_ARB_RR_EN in its reference model.
module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int BM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wd, m0_rd;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wd, m1_rd;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d, mem_q;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(SM), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rd(m0_rd), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rd(m1_rd), .m1_rvalid(m1_rvalid),
        .m1_lock(m1_lock),
        .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hA500_0000 + DW'(i) * 32'h0001_0203;
    endfunction

    // The dmem the arbiter drives
    logic [DW-1:0] env_mem [64];
    bit            env_ready = 1'b0;
    assign mem_q = env_mem[mem_a];

    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 64; i++)
                env_mem[i] <= init_val(i);
            env_ready <= 1'b1;
        end else if (mem_we) begin
            env_mem[mem_a] <= mem_d;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [64];
    int            starve, beats, last;
    bit            locked;
    bit            rv0, rv1;
    logic [DW-1:0] rd0, rd1;

    bit            c_rst, c_r0, c_we0, c_r1, c_we1, c_lk, c_g0, c_g1;
    logic [AW-1:0] c_a0, c_a1;
    logic [DW-1:0] c_d0, c_d1;

    typedef struct {
        bit            g0, g1, we, rv0, rv1;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd0, rd1;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Apply the rising edge that closes the current cycle
    task automatic model_edge();
        if (!c_rst) begin
            starve = 0; beats = 0; locked = 0; last = 1;
            rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0;
            return;
        end
        rv0 = c_g0 && !c_we0;
        rv1 = c_g1 && !c_we1;
        if (rv0) rd0 = ref_mem[c_a0];
        if (rv1) rd1 = ref_mem[c_a1];
        if (c_g0 && c_we0) ref_mem[c_a0] = c_d0;
        if (c_g1 && c_we1) ref_mem[c_a1] = c_d1;
        if (!c_r1 || c_g1) starve = 0;
        else if (starve < SM) starve++;
        if (c_r0 && c_r1) last = c_g1 ? 1 : 0;
        if (!locked) begin
            if (c_g1 && c_lk) begin
                locked = 1; beats = 1;
            end
        end else if (!c_lk || !c_r1 || beats == BM) begin
            locked = 0; beats = 0;
        end else begin
            beats++;
        end
    endtask

    // Who owns the port this cycle
    task automatic model_grant();
        c_g0 = 0; c_g1 = 0;
        if (!c_rst) return;
        if (locked && beats == BM && c_r0)
            c_g0 = 1;
        else if (locked && c_r1)
            c_g1 = 1;
        else if (c_r0 && c_r1) begin
`ifdef DMEM_ARB_RR_EN
            if (last == 0) c_g1 = 1;
            else c_g0 = 1;
`else
            if (starve >= SM) c_g1 = 1;
            else c_g0 = 1;
`endif
        end else begin
            c_g0 = c_r0;
            c_g1 = c_r1;
        end
    endtask

    task automatic step(
        input bit rs,
        input bit r0, input bit we0, input logic [AW-1:0] a0,
        input logic [DW-1:0] d0,
        input bit r1, input bit we1, input logic [AW-1:0] a1,
        input logic [DW-1:0] d1,
        input bit lk
    );
        exp_t e;
        @(negedge clk);
        model_edge();
        c_rst = rs; c_r0 = r0; c_we0 = we0; c_a0 = a0; c_d0 = d0;
        c_r1 = r1; c_we1 = we1; c_a1 = a1; c_d1 = d1; c_lk = lk;
        rst = rs; m0_req = r0; m0_we = we0; m0_addr = a0; m0_wd = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wd = d1; m1_lock = lk;
        model_grant();
        e.g0  = c_g0;
        e.g1  = c_g1;
        e.we  = (c_g0 && c_we0) || (c_g1 && c_we1);
        e.a   = c_g1 ? c_a1 : c_a0;
        e.d   = c_g1 ? c_d1 : c_d0;
        e.rv0 = rv0;
        e.rv1 = rv1;
        e.rd0 = rd0;
        e.rd1 = rd1;
        e.cyc = cyc;
        cyc++;
        q.push_back(e);
    endtask

    // Random masters that hold a pending request until granted
    task automatic rstep(input int p0, input int p1, input bit lk,
                         input bit rs);
        bit            r0, w0, r1, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        if (c_r0 && !c_g0) begin
            r0 = 1; w0 = c_we0; a0 = c_a0; d0 = c_d0;
        end else begin
            r0 = $urandom_range(99) < p0;
            w0 = $urandom_range(1) == 1;
            a0 = AW'($urandom);
            d0 = $urandom;
        end
        if (c_r1 && !c_g1) begin
            r1 = 1; w1 = c_we1; a1 = c_a1; d1 = c_d1;
        end else begin
            r1 = $urandom_range(99) < p1;
            w1 = $urandom_range(1) == 1;
            a1 = AW'($urandom);
            d1 = $urandom;
        end
        step(rs, r0, w0, a0, d0, r1, w1, a1, d1, lk);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp, input int cy);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cy, act, exp);
    endtask

    // Monitor: compare every presented cycle against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("m0_gnt", m0_gnt, e.g0, e.cyc);
                chk("m1_gnt", m1_gnt, e.g1, e.cyc);
                chk("mem_we", mem_we, e.we, e.cyc);
                chk("mem_a", mem_a, e.a, e.cyc);
                chk("mem_d", mem_d, e.d, e.cyc);
                chk("m0_rvalid", m0_rvalid, e.rv0, e.cyc);
                chk("m1_rvalid", m1_rvalid, e.rv1, e.cyc);
                chk("m0_rd", m0_rd, e.rd0, e.cyc);
                chk("m1_rd", m1_rd, e.rd1, e.cyc);
            end
        end
    end

    initial begin
        int p0, p1, guard;
        for (int i = 0; i < 64; i++)
            ref_mem[i] = init_val(i);
        c_rst = 0; c_r0 = 0; c_we0 = 0; c_r1 = 0; c_we1 = 0; c_lk = 0;
        c_g0 = 0; c_g1 = 0; c_a0 = '0; c_a1 = '0; c_d0 = '0; c_d1 = '0;
        starve = 0; beats = 0; locked = 0; last = 1;
        rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0;
        rst = 0; m0_req = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wd = '0; m1_lock = 0;

        // Reset held with both masters asking to write
        repeat (3)
            step(0, 1, 1, 6'd5, 32'h1111_1111, 1, 1, 6'd9, 32'h2222_2222, 0);

        // Master 0 write then read back addr 5
        step(1, 1, 1, 6'd5, 32'hDEAD_BEEF, 0, 0, 6'd0, '0, 0);
        step(1, 1, 0, 6'd5, 32'h0, 0, 0, 6'd0, '0, 0);
        step(1, 0, 0, 6'd5, 32'h0, 0, 0, 6'd0, '0, 0);
        step(1, 0, 0, 6'd5, 32'h0, 0, 0, 6'd0, '0, 0);

        // Continuous contention without lock
        repeat (24) rstep(100, 100, 0, 1);

        // Continuous contention with lock
        repeat (40) rstep(100, 100, 1, 1);

        // Reset pulse in the middle of a locked burst
        guard = 0;
        while (!(locked && beats == 3) && guard < 60) begin
            rstep(100, 100, 1, 1);
            guard++;
        end
        chk("reach_mid_burst", 32'(guard < 60), 32'd1, cyc);
        rstep(100, 100, 1, 0);
        repeat (12) rstep(100, 100, 1, 1);

        // Randomized traffic
        for (int s = 0; s < 12; s++) begin
            p0 = $urandom_range(20, 100);
            p1 = $urandom_range(20, 100);
            repeat (100)
                rstep(p0, p1, $urandom_range(9) < 7,
                      $urandom_range(99) != 0);
        end

        repeat (3) step(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
